// File: rtl/inst_mem_if.sv
// Instruction-memory interface: one-word fetch over a variable-latency bus with a
// single-entry last-word buffer, bus timeout and fault reporting.
module inst_mem_if #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     AWIDTH   = 14,
  parameter int unsigned     TIMEOUT  = 255,
  parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              phase_fetch,
  input  logic [AWIDTH-1:0] inst_addr,
  input  logic              invalidate,
  output logic [XLEN-1:0]   inst_data,
  output logic              stall_fetch,
  output logic              fetch_fault,
  output logic              bus_req,
  output logic [AWIDTH-1:0] bus_addr,
  input  logic              bus_ack,
  input  logic              bus_err,
  input  logic [XLEN-1:0]   bus_rdata
);

  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e            state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic [AWIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [XLEN-1:0]   inst_data_q, inst_data_d;
  logic              fault_q, fault_d;
  logic              buf_valid_q, buf_valid_d;
  logic [AWIDTH-1:0] buf_tag_q, buf_tag_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              hit;

  assign hit = buf_valid_q & (buf_tag_q == inst_addr);

  assign stall_fetch = ((state_q == StIdle) & phase_fetch & ~hit) | (state_q == StReq);
  assign inst_data   = inst_data_q;
  assign fetch_fault = fault_q;
  assign bus_req     = bus_req_q;
  assign bus_addr    = bus_addr_q;

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_addr_d  = bus_addr_q;
    inst_data_d = inst_data_q;
    fault_d     = fault_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    cnt_d       = cnt_q;

    if (invalidate) begin
      buf_valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (phase_fetch && !hit) begin
          state_d    = StReq;
          bus_req_d  = 1'b1;
          bus_addr_d = inst_addr;
          cnt_d      = '0;
          fault_d    = 1'b0;
        end
      end
      StReq: begin
        // An ack in the cycle the timeout would fire takes priority.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = StDone;
          if (bus_err) begin
            inst_data_d = NOP_INST;
            buf_valid_d = 1'b0;
            fault_d     = 1'b1;
          end else begin
            inst_data_d = bus_rdata;
            buf_tag_d   = bus_addr_q;
            buf_valid_d = ~invalidate;
          end
        end else if (cnt_q == CntLast) begin
          inst_data_d = NOP_INST;
          buf_valid_d = 1'b0;
          fault_d     = 1'b1;
          bus_req_d   = 1'b0;
          state_d     = StDone;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      inst_data_q <= NOP_INST;
      fault_q     <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      inst_data_q <= inst_data_d;
      fault_q     <= fault_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_inst_mem_if.sv
// Randomized bench for inst_mem_if with a transaction-level model of the fetch buffer,
// latency, timeout and fault behaviour.
module tb_inst_mem_if;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 14;
  localparam int unsigned TO   = 4;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic            clk;
  logic            rst_n;
  logic            phase_fetch;
  logic [AW-1:0]   inst_addr;
  logic            invalidate;
  logic [XLEN-1:0] inst_data;
  logic            stall_fetch;
  logic            fetch_fault;
  logic            bus_req;
  logic [AW-1:0]   bus_addr;
  logic            bus_ack;
  logic            bus_err;
  logic [XLEN-1:0] bus_rdata;

  int checks;
  int failures;

  // Reference model state: what the buffer and output registers should hold.
  bit            m_valid;
  logic [AW-1:0] m_tag;
  logic [31:0]   m_data;
  bit            m_fault;

  inst_mem_if #(
    .XLEN    (XLEN),
    .AWIDTH  (AW),
    .TIMEOUT (TO),
    .NOP_INST(NOP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .phase_fetch(phase_fetch),
    .inst_addr  (inst_addr),
    .invalidate (invalidate),
    .inst_data  (inst_data),
    .stall_fetch(stall_fetch),
    .fetch_fault(fetch_fault),
    .bus_req    (bus_req),
    .bus_addr   (bus_addr),
    .bus_ack    (bus_ack),
    .bus_err    (bus_err),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One fetch phase; the bus responder acks in REQ cycle wait_n+1 (never if beyond TIMEOUT).
  task automatic do_fetch(input logic [AW-1:0] addr, input int wait_n, input bit err,
                          input logic [31:0] rdata, input bit inv_at_ack);
    int  stall_cnt = 0;
    int  req_cnt   = 0;
    int  cyc       = 0;
    bit  fin       = 0;
    bit  addr_ok   = 1;
    bit  exp_hit;
    int  exp_req;
    logic [31:0] exp_data;
    bit  exp_fault;
    bit  exp_valid;

    exp_hit = m_valid && (m_tag == addr);
    if (exp_hit) begin
      exp_req   = 0;
      exp_data  = m_data;
      exp_fault = m_fault;
      exp_valid = 1;
    end else if (wait_n < int'(TO)) begin
      exp_req   = wait_n + 1;
      exp_data  = err ? NOP : rdata;
      exp_fault = err;
      exp_valid = !err && !inv_at_ack;
    end else begin
      exp_req   = TO;
      exp_data  = NOP;
      exp_fault = 1;
      exp_valid = 0;
    end

    @(negedge clk);
    inst_addr   = addr;
    phase_fetch = 1'b1;
    while (!fin && cyc < 300) begin
      #1;
      invalidate = 1'b0;
      if (bus_req) begin
        req_cnt++;
        if (bus_addr != addr) addr_ok = 0;
        bus_ack   = (req_cnt == wait_n + 1);
        bus_err   = bus_ack ? err : 1'($urandom_range(0, 1));
        bus_rdata = bus_ack ? rdata : $urandom;
        if (bus_ack && inv_at_ack) invalidate = 1'b1;
      end else begin
        bus_ack = 1'b0;
        bus_err = 1'b0;
      end
      if (stall_fetch) begin
        stall_cnt++;
      end else begin
        fin = 1;
        check_eq("inst_data", inst_data, exp_data);
        check_eq("fetch_fault", 32'(fetch_fault), 32'(exp_fault));
      end
      cyc++;
      @(negedge clk);
    end
    phase_fetch = 1'b0;
    bus_ack     = 1'b0;
    bus_err     = 1'b0;
    invalidate  = 1'b0;
    if (!fin) check_eq("fetch_timeout_bound", 32'(cyc), 32'(0));
    check_eq("req_cycles", 32'(req_cnt), 32'(exp_req));
    check_eq("stall_cycles", 32'(stall_cnt), 32'(exp_hit ? 0 : exp_req + 1));
    check_eq("bus_addr_stable", 32'(addr_ok), 32'(1));

    m_data  = exp_data;
    m_fault = exp_fault;
    m_valid = exp_valid;
    if (!exp_hit) m_tag = addr;
  endtask

  task automatic pulse_inv();
    @(negedge clk);
    invalidate = 1'b1;
    @(negedge clk);
    invalidate = 1'b0;
    m_valid = 0;
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_tag   = '0;
    m_data  = NOP;
    m_fault = 0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    phase_fetch = 1'b0;
    inst_addr   = '0;
    invalidate  = 1'b0;
    bus_ack     = 1'b0;
    bus_err     = 1'b0;
    bus_rdata   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_inst_data", inst_data, NOP);
    check_eq("rst_bus_req", 32'(bus_req), 32'(0));
    check_eq("rst_bus_addr", 32'(bus_addr), 32'(0));
    check_eq("rst_stall", 32'(stall_fetch), 32'(0));
    check_eq("rst_fault", 32'(fetch_fault), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed sequence
    do_fetch(14'h000, 0, 0, 32'h0050_0093, 0);
    do_fetch(14'h000, 0, 0, 32'hdead_beef, 0);
    pulse_inv();
    do_fetch(14'h000, 0, 0, 32'h0050_0093, 0);
    do_fetch(14'h004, 5 - 1 + 1 > int'(TO) ? 2 : 5, 0, 32'h1234_5678, 0);
    do_fetch(14'h008, 0, 1, 32'hffff_ffff, 0);
    do_fetch(14'h00c, 1, 0, 32'h00a0_0113, 0);
    do_fetch(14'h010, 10, 0, 32'h5555_aaaa, 0);
    do_fetch(14'h014, 3, 0, 32'h0c0f_fee0, 0);
    do_fetch(14'h014, 0, 0, 32'h0, 0);
    do_fetch(14'h018, 0, 0, 32'h7777_1111, 1);
    do_fetch(14'h018, 0, 0, 32'h7777_2222, 0);

    // Reset while a request is outstanding
    @(negedge clk);
    inst_addr   = 14'h020;
    phase_fetch = 1'b1;
    repeat (3) @(negedge clk);
    rst_n       = 1'b0;
    phase_fetch = 1'b0;
    #1;
    check_eq("midrst_bus_req", 32'(bus_req), 32'(0));
    check_eq("midrst_stall", 32'(stall_fetch), 32'(0));
    check_eq("midrst_inst_data", inst_data, NOP);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_fetch(14'h018, 0, 0, 32'h0bad_c0de, 0);

    // Randomized fetch stream
    for (int i = 0; i < 60; i++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 3) * 4);
      if ($urandom_range(0, 9) == 0) pulse_inv();
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      do_fetch(a, int'($urandom_range(0, 6)), ($urandom_range(0, 5) == 0),
               $urandom, ($urandom_range(0, 4) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
